// File: rtl/wb_sel_if.sv
// Bundle of the MEM-stage handshake, the data-memory read response and
// the register-file write port seen by the writeback selector.
interface wb_sel_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    // MEM-stage instruction handshake
    logic               valid_i;
    logic               ready_o;
    logic [1:0]         WBSel_i;
    logic               RegWEn_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic [XLEN-1:0]    alu_i;
    logic [XLEN-1:0]    pc_i;
    logic [2:0]         funct3_i;
    logic [1:0]         addr_lo_i;

    // data-memory read response
    logic               dmem_rvalid_i;
    logic [XLEN-1:0]    dmem_rdata_i;

    // register-file write port and status
    logic               reg_we_o;
    logic [RADDR_W-1:0] reg_waddr_o;
    logic [XLEN-1:0]    reg_wdata_o;
    logic               busy_o;

    // pipeline side: drives the instruction and the memory response
    modport master (
        output valid_i, WBSel_i, RegWEn_i, rd_addr_i, alu_i, pc_i,
               funct3_i, addr_lo_i, dmem_rvalid_i, dmem_rdata_i,
        input  ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, busy_o
    );

    // writeback selector side
    modport slave (
        input  valid_i, WBSel_i, RegWEn_i, rd_addr_i, alu_i, pc_i,
               funct3_i, addr_lo_i, dmem_rvalid_i, dmem_rdata_i,
        output ready_o, reg_we_o, reg_waddr_o, reg_wdata_o, busy_o
    );
endinterface

// File: rtl/wb_sel.sv
// Writeback source selector: picks ALU result, load data or PC+4 for the
// register file, waiting for the data-memory response on loads.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads retire in 1 cycle
// WAIT_MEM | load accepted, waiting for dmem_rvalid_i
module wb_sel #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic     clk_i,
    input logic     rst_n_i,
    wb_sel_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    state_t             state_q, state_d;

    // load context captured at accept time
    logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic               ld_we_q, ld_we_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [1:0]         ld_lo_q, ld_lo_d;

    // registered register-file write port
    logic               we_q, we_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;

    logic               accept;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [XLEN-1:0]    load_ext;
    logic [XLEN-1:0]    nonload_data;

    assign accept = bus.valid_i && (state_q == IDLE);

    // Pick the addressed byte/halfword out of the returned word.
    always_comb begin
        byte_sel = bus.dmem_rdata_i[7:0];
        case (ld_lo_q)
            2'd0:    byte_sel = bus.dmem_rdata_i[7:0];
            2'd1:    byte_sel = bus.dmem_rdata_i[15:8];
            2'd2:    byte_sel = bus.dmem_rdata_i[23:16];
            default: byte_sel = bus.dmem_rdata_i[31:24];
        endcase
        // halfword loads ignore addr_lo[0]; misalignment is upstream's problem
        half_sel = ld_lo_q[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
    end

    // Sign/zero-extend by load type; reserved encodings behave as LW.
    always_comb begin
        load_ext = bus.dmem_rdata_i;
        case (ld_f3_q)
            F3_LB:   load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
            default: load_ext = bus.dmem_rdata_i;
        endcase
    end

    // Non-load result: PC+4 for links, otherwise the ALU result (WBSel 3 too).
    always_comb begin
        if (bus.WBSel_i == SEL_PC4) begin
            nonload_data = bus.pc_i + XLEN'(4);
        end else begin
            nonload_data = bus.alu_i;
        end
    end

    // Next-state, load capture and write-port update.
    always_comb begin
        state_d = state_q;
        ld_rd_d = ld_rd_q;
        ld_we_d = ld_we_q;
        ld_f3_d = ld_f3_q;
        ld_lo_d = ld_lo_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.WBSel_i == SEL_MEM) begin
                        ld_rd_d = bus.rd_addr_i;
                        ld_we_d = bus.RegWEn_i;
                        ld_f3_d = bus.funct3_i;
                        ld_lo_d = bus.addr_lo_i;
                        state_d = WAIT_MEM;
                    end else begin
                        we_d = bus.RegWEn_i && (bus.rd_addr_i != '0);
                        // address/data only move on a real write so they
                        // hold their last values while we is low
                        if (we_d) begin
                            waddr_d = bus.rd_addr_i;
                            wdata_d = nonload_data;
                        end
                    end
                end
                // a response arriving in IDLE is stray and dropped
            end
            WAIT_MEM: begin
                if (bus.dmem_rvalid_i) begin
                    we_d = ld_we_q && (ld_rd_q != '0);
                    if (we_d) begin
                        waddr_d = ld_rd_q;
                        wdata_d = load_ext;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, load context and write port registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ld_rd_q <= '0;
            ld_we_q <= 1'b0;
            ld_f3_q <= '0;
            ld_lo_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ld_rd_q <= ld_rd_d;
            ld_we_q <= ld_we_d;
            ld_f3_q <= ld_f3_d;
            ld_lo_q <= ld_lo_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.ready_o     = (state_q == IDLE);
    assign bus.busy_o      = (state_q == WAIT_MEM);
    assign bus.reg_we_o    = we_q;
    assign bus.reg_waddr_o = waddr_q;
    assign bus.reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_sel.sv
// Directed bench for wb_sel: ALU/PC+4 writes, load extraction, stream
// ordering, stray responses and reset in the middle of a load.
module tb_wb_sel;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_sel_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

    wb_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock and settle just past the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_i       = 1'b0;
        bus.WBSel_i       = 2'd0;
        bus.RegWEn_i      = 1'b0;
        bus.rd_addr_i     = '0;
        bus.alu_i         = '0;
        bus.pc_i          = '0;
        bus.funct3_i      = 3'd0;
        bus.addr_lo_i     = 2'd0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = '0;
    endtask

    task automatic present(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [2:0] f3, input logic [1:0] lo);
        bus.valid_i   = 1'b1;
        bus.WBSel_i   = sel;
        bus.RegWEn_i  = wen;
        bus.rd_addr_i = rd;
        bus.alu_i     = alu;
        bus.pc_i      = pc;
        bus.funct3_i  = f3;
        bus.addr_lo_i = lo;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.reg_we_o); end
        checks++; if (bus.reg_waddr_o !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", bus.reg_waddr_o); end
        checks++; if (bus.reg_wdata_o !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.reg_wdata_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    endtask

    task automatic test_alu_write();
        present(2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", bus.reg_we_o); end
        checks++; if (bus.reg_waddr_o !== 5'd5) begin failures++; $display("FAIL alu_waddr got=%0d exp=5", bus.reg_waddr_o); end
        checks++; if (bus.reg_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL alu_wdata got=%h exp=12345678", bus.reg_wdata_o); end
        tick();
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%b exp=0", bus.reg_we_o); end
        checks++; if (bus.reg_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL alu_hold got=%h exp=12345678", bus.reg_wdata_o); end
        // reserved select behaves as ALU
        present(2'd3, 1'b1, 5'd9, 32'hA5A5_0001, 32'h0000_4000, 3'd0, 2'd0);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_wdata_o !== 32'hA5A5_0001) begin failures++; $display("FAIL sel3_wdata got=%h exp=a5a50001", bus.reg_wdata_o); end
        tick();
    endtask

    task automatic test_pc4();
        present(2'd2, 1'b1, 5'd1, 32'hDEAD_0000, 32'hFFFF_FFFC, 3'd0, 2'd0);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b1) begin failures++; $display("FAIL jal_we got=%b exp=1", bus.reg_we_o); end
        checks++; if (bus.reg_waddr_o !== 5'd1) begin failures++; $display("FAIL jal_waddr got=%0d exp=1", bus.reg_waddr_o); end
        checks++; if (bus.reg_wdata_o !== 32'h0) begin failures++; $display("FAIL jal_wrap got=%h exp=0", bus.reg_wdata_o); end
        tick();
        present(2'd2, 1'b1, 5'd0, 32'h0, 32'h0000_0100, 3'd0, 2'd0);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL rd0_we got=%b exp=0", bus.reg_we_o); end
        present(2'd0, 1'b0, 5'd7, 32'h0000_0777, 32'h0, 3'd0, 2'd0);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL nowen_we got=%b exp=0", bus.reg_we_o); end
        tick();
    endtask

    // Issue one load, hold off rvalid for lat cycles, then check the write.
    task automatic run_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] rdata, input logic wen, input logic [4:0] rd,
                            input int lat, input logic [31:0] exp);
        present(2'd1, wen, rd, 32'h5555_5555, 32'h0, f3, lo);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL %s accept_we got=%b exp=0", name, bus.reg_we_o); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL %s busy got=%b exp=1", name, bus.busy_o); end
        for (int i = 0; i < lat; i++) begin
            checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL %s wait_ready c%0d got=%b exp=0", name, i, bus.ready_o); end
            if (i == lat - 1) begin
                bus.dmem_rvalid_i = 1'b1;
                bus.dmem_rdata_i  = rdata;
            end
            tick();
        end
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = 32'hFFFF_FFFF;
        checks++; if (bus.reg_we_o !== wen) begin failures++; $display("FAIL %s we got=%b exp=%b", name, bus.reg_we_o, wen); end
        if (wen) begin
            checks++; if (bus.reg_wdata_o !== exp) begin failures++; $display("FAIL %s wdata got=%h exp=%h", name, bus.reg_wdata_o, exp); end
            checks++; if (bus.reg_waddr_o !== rd) begin failures++; $display("FAIL %s waddr got=%0d exp=%0d", name, bus.reg_waddr_o, rd); end
        end
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL %s done_ready got=%b exp=1", name, bus.ready_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL %s done_busy got=%b exp=0", name, bus.busy_o); end
        tick();
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL %s pulse got=%b exp=0", name, bus.reg_we_o); end
    endtask

    task automatic test_loads();
        run_load("lb_lo2",   3'd0, 2'd2, 32'h0080_0000, 1'b1, 5'd10, 3, 32'hFFFF_FF80);
        run_load("lhu_lo2",  3'd5, 2'd2, 32'hBEEF_1234, 1'b1, 5'd11, 1, 32'h0000_BEEF);
        run_load("lh_lo0",   3'd1, 2'd0, 32'h1234_8001, 1'b1, 5'd12, 2, 32'hFFFF_8001);
        run_load("lh_lo3",   3'd1, 2'd3, 32'h7FFF_0000, 1'b1, 5'd13, 1, 32'h0000_7FFF);
        run_load("lbu_lo3",  3'd4, 2'd3, 32'h8000_0000, 1'b1, 5'd14, 1, 32'h0000_0080);
        run_load("lb_lo1",   3'd0, 2'd1, 32'h0000_7F00, 1'b1, 5'd15, 1, 32'h0000_007F);
        run_load("lw",       3'd2, 2'd1, 32'hDEAD_BEEF, 1'b1, 5'd16, 2, 32'hDEAD_BEEF);
        run_load("f3_6_lw",  3'd6, 2'd3, 32'h8765_4321, 1'b1, 5'd17, 1, 32'h8765_4321);
        run_load("ld_nowen", 3'd2, 2'd0, 32'h1111_1111, 1'b0, 5'd18, 1, 32'h0);
        run_load("ld_rd0",   3'd2, 2'd0, 32'h2222_2222, 1'b0, 5'd0,  1, 32'h0);
    endtask

    task automatic test_back_to_back();
        present(2'd0, 1'b1, 5'd2, 32'h0000_0011, 32'h0, 3'd0, 2'd0);
        tick();
        checks++; if (bus.reg_we_o !== 1'b1 || bus.reg_waddr_o !== 5'd2 || bus.reg_wdata_o !== 32'h11)
            begin failures++; $display("FAIL b2b_w1 got=%b/%0d/%h exp=1/2/11", bus.reg_we_o, bus.reg_waddr_o, bus.reg_wdata_o); end
        present(2'd0, 1'b1, 5'd3, 32'h0000_0022, 32'h0, 3'd0, 2'd0);
        tick();
        checks++; if (bus.reg_we_o !== 1'b1 || bus.reg_waddr_o !== 5'd3 || bus.reg_wdata_o !== 32'h22)
            begin failures++; $display("FAIL b2b_w2 got=%b/%0d/%h exp=1/3/22", bus.reg_we_o, bus.reg_waddr_o, bus.reg_wdata_o); end
        present(2'd1, 1'b1, 5'd4, 32'h0, 32'h0, 3'd2, 2'd0);
        tick();
        checks++; if (bus.reg_we_o !== 1'b0 || bus.ready_o !== 1'b0)
            begin failures++; $display("FAIL b2b_ld_accept got we=%b ready=%b exp we=0 ready=0", bus.reg_we_o, bus.ready_o); end
        // next instruction is held on the bus while the load is outstanding
        present(2'd0, 1'b1, 5'd6, 32'h0000_0066, 32'h0, 3'd0, 2'd0);
        tick();
        checks++; if (bus.reg_we_o !== 1'b0 || bus.ready_o !== 1'b0)
            begin failures++; $display("FAIL b2b_held got we=%b ready=%b exp we=0 ready=0", bus.reg_we_o, bus.ready_o); end
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'hCAFE_F00D;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b1 || bus.reg_waddr_o !== 5'd4 || bus.reg_wdata_o !== 32'hCAFE_F00D)
            begin failures++; $display("FAIL b2b_w3 got=%b/%0d/%h exp=1/4/cafef00d", bus.reg_we_o, bus.reg_waddr_o, bus.reg_wdata_o); end
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", bus.ready_o); end
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b1 || bus.reg_waddr_o !== 5'd6 || bus.reg_wdata_o !== 32'h66)
            begin failures++; $display("FAIL b2b_w4 got=%b/%0d/%h exp=1/6/66", bus.reg_we_o, bus.reg_waddr_o, bus.reg_wdata_o); end
        tick();
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%b exp=0", bus.reg_we_o); end
    endtask

    task automatic test_stray_rvalid();
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h0BAD_0BAD;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL stray_we got=%b exp=0", bus.reg_we_o); end
        checks++; if (bus.reg_wdata_o !== 32'h0000_0066) begin failures++; $display("FAIL stray_hold got=%h exp=66", bus.reg_wdata_o); end
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL stray_ready got=%b exp=1", bus.ready_o); end
    endtask

    task automatic test_reset_mid_load();
        present(2'd1, 1'b1, 5'd7, 32'h0, 32'h0, 3'd2, 2'd0);
        tick();
        bus.valid_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL rst_ld_busy got=%b exp=1", bus.busy_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b1)
            begin failures++; $display("FAIL rst_ld_async got busy=%b ready=%b exp busy=0 ready=1", bus.busy_o, bus.ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        // the response for the discarded load must not write
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h7777_7777;
        tick();
        bus.dmem_rvalid_i = 1'b0;
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL rst_ld_we got=%b exp=0", bus.reg_we_o); end
        checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got=%b exp=1", bus.ready_o); end
        checks++; if (bus.reg_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_ld_wdata got=%h exp=0", bus.reg_wdata_o); end
        tick();
        checks++; if (bus.reg_we_o !== 1'b0) begin failures++; $display("FAIL rst_ld_quiet got=%b exp=0", bus.reg_we_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_write();
        test_pc4();
        test_loads();
        test_back_to_back();
        test_stray_rvalid();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
